maxpool_scheduler: RTL
======================

Name: maxpool_scheduler

Overview:
Sequences a 2x2/stride-2 max-pool FPU unit over a full CHW tensor in word-addressed memory. It accepts one job descriptor, then walks channels, output rows and output columns. For each window it presents four input addresses and one output address, pulses unit_go, and waits for unit_done. It sits between the command decoder and the max-pool forward unit and owns all address generation for that unit.

Parameters:
ADDR_W, 32, width of all word addresses
DIM_W, 16, width of the height, width and channel fields

Ports:
clk  input  1  system clock
rst_l  input  1  synchronous active-low reset
cfg_valid  input  1  job descriptor valid
cfg_ready  output  1  scheduler can accept a job (high only in IDLE)
in_base  input  ADDR_W  input tensor base word address
out_base  input  ADDR_W  output tensor base word address
in_h  input  DIM_W  input height
in_w  input  DIM_W  input width
in_c  input  DIM_W  channel count
unit_go  output  1  one-cycle start pulse to the max-pool unit
unit_done  input  1  one-cycle completion pulse from the max-pool unit
addr_a  output  ADDR_W  window top-left
addr_b  output  ADDR_W  window top-right (addr_a+1)
addr_c  output  ADDR_W  window bottom-left (addr_a+in_w)
addr_d  output  ADDR_W  window bottom-right (addr_a+in_w+1)
addr_out  output  ADDR_W  result word address
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at job end
error  output  1  valid with done; job rejected for bad dimensions
win_count  output  32  windows completed in the current or last job

Behaviour:
- Reset is synchronous on rst_l==0 and wins over everything, including mid-job.
  - State returns to IDLE.
  - unit_go, done, error, busy, win_count and all addr_* outputs go to 0.
  - Job registers are cleared; an in-flight unit_done is ignored after reset.
- States: IDLE, CHECK, ISSUE, WAIT, STEP, FINISH.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch the descriptor, clear win_count and go to CHECK.
  - cfg_valid outside IDLE is ignored; cfg_ready=0 there.
- CHECK (1 cycle):
  - If in_h<2, in_w<2 or in_c==0: set error=1 and go to FINISH.
  - Otherwise:
    - Register plane = in_h*in_w (truncated to ADDR_W).
    - Set oh=in_h>>1 and ow=in_w>>1.
    - Zero the counters ch, oy, ox.
    - Set chan_base = row_base = addr_a = in_base and addr_out = out_base.
    - Go to ISSUE.
- ISSUE (1 cycle):
  - unit_go=1.
  - addr_* are valid from this cycle and held stable until leaving WAIT.
  - Go to WAIT.
- WAIT:
  - Hold all outputs.
  - On unit_done: win_count += 1, then go to STEP.
  - unit_done is sampled only in WAIT and ignored in every other state.
- STEP (1 cycle): advance the counters, innermost ox, then oy, then ch.
  - Column step: addr_a += 2.
  - Row wrap (ox==ow-1): ox=0; row_base += 2*in_w; addr_a = new row_base.
  - Channel wrap (oy==oh-1 as well): oy=0; chan_base += plane; row_base = addr_a = new chan_base.
  - addr_out += 1 on every step, so output is contiguous (ch, oy, ox).
  - If ch==in_c-1, oy==oh-1 and ox==ow-1: go to FINISH; else go to ISSUE.
- Derived addresses: addr_b/c/d are combinational from addr_a and the latched in_w. Adds are modulo 2^ADDR_W.
- Odd dimensions: the last odd input row and column are skipped (floor). The channel stride is still the full plane.
- FINISH (1 cycle):
  - done=1; error holds the result of CHECK.
  - Go to IDLE.
  - error stays valid until the next accepted cfg, which clears it.
- Timing:
  - Minimum cost per window is 3 cycles (ISSUE, WAIT with same-cycle done, STEP) plus unit latency.
  - Job overhead is 2 cycles (CHECK, FINISH).
- No multiply in the per-window path; the only multiply is plane, computed in CHECK.

Test Plan:
- Reset mid-job:
  - Stimulus: 4x4x1 job; assert rst_l=0 while in WAIT.
  - Response: next cycle busy=0, cfg_ready=1, win_count=0.
  - Then: a unit_done pulse arriving afterwards causes no state change.
- 4x4x1 nominal job:
  - Stimulus: in_base=0x100, out_base=0x200; unit returns done 2 cycles after go.
  - Window addr_a sequence: 0x100, 0x102, 0x108, 0x10A.
  - First window: addr_b=0x101, addr_c=0x104, addr_d=0x105.
  - addr_out: 0x200 to 0x203.
  - End: exactly 4 unit_go pulses, then a done pulse with error=0 and win_count=4.
- 5x5x2 odd dimensions and channel stride:
  - Stimulus: in_base=0.
  - addr_a sequence: 0, 2, 10, 12, then 25, 27, 35, 37.
  - First window addr_c=5; addr_out runs 0 to 7.
- Bad dimensions:
  - Stimulus: in_h=1 (separately in_c=0).
  - Response: no unit_go; done and error pulse 2 cycles after the cfg handshake.
  - Follow-up: a valid cfg next clears error.
- Handshake robustness:
  - cfg_valid held high during a job must not restart it.
  - unit_done asserted during ISSUE or IDLE must be ignored.
  - Back-to-back jobs: cfg_ready returns the cycle after done.
- Address wrap:
  - Stimulus: in_base=0xFFFF_FFFE, in_w=in_h=2, in_c=1.
  - Response: addr_b=0xFFFF_FFFF, addr_c=0x0000_0000, addr_d=0x0000_0001.

Source files
------------

// File: rtl/maxpool_scheduler.sv
// Address sequencer for a 2x2/stride-2 max-pool unit over a CHW tensor.
// Takes one job descriptor, then issues one unit_go per output window and waits for unit_done.
module maxpool_scheduler #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_c,
  output logic              unit_go,
  input  logic              unit_done,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic [ADDR_W-1:0] addr_d,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       win_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_STEP   = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] in_base_q,   in_base_d;
  logic [ADDR_W-1:0] out_base_q,  out_base_d;
  logic [DIM_W-1:0]  in_h_q,      in_h_d;
  logic [DIM_W-1:0]  in_w_q,      in_w_d;
  logic [DIM_W-1:0]  in_c_q,      in_c_d;
  logic [DIM_W-1:0]  oh_q,        oh_d;
  logic [DIM_W-1:0]  ow_q,        ow_d;
  logic [DIM_W-1:0]  ch_q,        ch_d;
  logic [DIM_W-1:0]  oy_q,        oy_d;
  logic [DIM_W-1:0]  ox_q,        ox_d;
  logic [ADDR_W-1:0] plane_q,     plane_d;
  logic [ADDR_W-1:0] chan_base_q, chan_base_d;
  logic [ADDR_W-1:0] row_base_q,  row_base_d;
  logic [ADDR_W-1:0] addr_a_q,    addr_a_d;
  logic [ADDR_W-1:0] addr_out_q,  addr_out_d;
  logic [CNT_W-1:0]  win_count_q, win_count_d;
  logic              error_q,     error_d;
  logic              addr_vld_q,  addr_vld_d;

  logic [ADDR_W-1:0] in_w_ext;
  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] next_chan_base;
  logic [ADDR_W-1:0] next_row_base;
  logic              dims_bad;
  logic              last_col;
  logic              last_row;
  logic              last_ch;

  // Per-window step helpers: only adds, the plane product is precomputed in CHECK
  assign in_w_ext       = ADDR_W'(in_w_q);
  assign row_stride     = in_w_ext << 1;
  assign next_chan_base = chan_base_q + plane_q;
  assign next_row_base  = row_base_q + row_stride;
  assign dims_bad       = (in_h_q < DIM_W'(2)) || (in_w_q < DIM_W'(2)) || (in_c_q == '0);
  assign last_col       = (ox_q == ow_q - DIM_W'(1));
  assign last_row       = (oy_q == oh_q - DIM_W'(1));
  assign last_ch        = (ch_q == in_c_q - DIM_W'(1));

  // State and job registers
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q     <= S_IDLE;
      in_base_q   <= '0;
      out_base_q  <= '0;
      in_h_q      <= '0;
      in_w_q      <= '0;
      in_c_q      <= '0;
      oh_q        <= '0;
      ow_q        <= '0;
      ch_q        <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      plane_q     <= '0;
      chan_base_q <= '0;
      row_base_q  <= '0;
      addr_a_q    <= '0;
      addr_out_q  <= '0;
      win_count_q <= '0;
      error_q     <= 1'b0;
      addr_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      in_h_q      <= in_h_d;
      in_w_q      <= in_w_d;
      in_c_q      <= in_c_d;
      oh_q        <= oh_d;
      ow_q        <= ow_d;
      ch_q        <= ch_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      plane_q     <= plane_d;
      chan_base_q <= chan_base_d;
      row_base_q  <= row_base_d;
      addr_a_q    <= addr_a_d;
      addr_out_q  <= addr_out_d;
      win_count_q <= win_count_d;
      error_q     <= error_d;
      addr_vld_q  <= addr_vld_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    in_h_d      = in_h_q;
    in_w_d      = in_w_q;
    in_c_d      = in_c_q;
    oh_d        = oh_q;
    ow_d        = ow_q;
    ch_d        = ch_q;
    oy_d        = oy_q;
    ox_d        = ox_q;
    plane_d     = plane_q;
    chan_base_d = chan_base_q;
    row_base_d  = row_base_q;
    addr_a_d    = addr_a_q;
    addr_out_d  = addr_out_q;
    win_count_d = win_count_q;
    error_d     = error_q;
    addr_vld_d  = addr_vld_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          in_base_d   = in_base;
          out_base_d  = out_base;
          in_h_d      = in_h;
          in_w_d      = in_w;
          in_c_d      = in_c;
          win_count_d = '0;
          error_d     = 1'b0;
          addr_vld_d  = 1'b0;
          state_d     = S_CHECK;
        end
      end

      S_CHECK: begin
        if (dims_bad) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          plane_d     = ADDR_W'(in_h_q) * in_w_ext;
          oh_d        = in_h_q >> 1;
          ow_d        = in_w_q >> 1;
          ch_d        = '0;
          oy_d        = '0;
          ox_d        = '0;
          chan_base_d = in_base_q;
          row_base_d  = in_base_q;
          addr_a_d    = in_base_q;
          addr_out_d  = out_base_q;
          addr_vld_d  = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (unit_done) begin
          win_count_d = win_count_q + CNT_W'(1);
          state_d     = S_STEP;
        end
      end

      S_STEP: begin
        addr_out_d = addr_out_q + ADDR_W'(1);
        if (!last_col) begin
          ox_d     = ox_q + DIM_W'(1);
          addr_a_d = addr_a_q + ADDR_W'(2);
        end else if (!last_row) begin
          ox_d       = '0;
          oy_d       = oy_q + DIM_W'(1);
          row_base_d = next_row_base;
          addr_a_d   = next_row_base;
        end else begin
          ox_d        = '0;
          oy_d        = '0;
          ch_d        = ch_q + DIM_W'(1);
          chan_base_d = next_chan_base;
          row_base_d  = next_chan_base;
          addr_a_d    = next_chan_base;
        end
        state_d = (last_col && last_row && last_ch) ? S_FINISH : S_ISSUE;
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status decodes straight from the state register
  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign unit_go   = (state_q == S_ISSUE);
  assign done      = (state_q == S_FINISH);
  assign error     = error_q;
  assign win_count = win_count_q;

  // Neighbour addresses are zero until a job has produced a valid window
  assign addr_a   = addr_a_q;
  assign addr_out = addr_out_q;
  assign addr_b   = addr_vld_q ? (addr_a_q + ADDR_W'(1))            : '0;
  assign addr_c   = addr_vld_q ? (addr_a_q + in_w_ext)              : '0;
  assign addr_d   = addr_vld_q ? (addr_a_q + in_w_ext + ADDR_W'(1)) : '0;

endmodule
